// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC and fetches one instruction per fetch phase over a req/valid handshake
module instruction_fetch #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            phase_fetch,
   input  logic            pc_update,
   input  logic            jump_taken,
   input  logic [XLEN-1:0] jump_target,
   output logic            inst_mem_req,
   output logic [XLEN-1:0] inst_mem_addr,
   input  logic [31:0]     inst_mem_rdata,
   input  logic            inst_mem_valid,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] curr_pc_fd,
   output logic [XLEN-1:0] next_pc_fd,
   output logic            stall_fetch,
   output logic            inst_misaligned
);
   typedef enum logic {IDLE, REQ} state_t;
   state_t state, state_next;
   logic [XLEN-1:0] pc_reg, pc_next;
   logic accept;
   assign pc_next = pc_update ? (jump_taken ? {jump_target[XLEN-1:2], 2'b00} : pc_reg + XLEN'(4)) : pc_reg;
   assign inst_mem_req = (state == REQ);
   assign accept = (state == REQ) && inst_mem_valid;
   assign stall_fetch = phase_fetch | (state == REQ);
   always_comb begin
      state_next = state;
      if (state == IDLE && phase_fetch)
         state_next = REQ;
      else if (accept)
         state_next = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         pc_reg          <= RESET_VECTOR;
         inst_mem_addr   <= RESET_VECTOR;
         inst            <= NOP_INST;
         curr_pc_fd      <= RESET_VECTOR;
         next_pc_fd      <= RESET_VECTOR + XLEN'(4);
         inst_misaligned <= 1'b0;
      end else begin
         state  <= state_next;
         pc_reg <= pc_next;
         if (pc_update)
            inst_misaligned <= jump_taken & (jump_target[1:0] != 2'b00);
         // the address is latched only on fetch start so it stays stable while req is high
         if (state == IDLE && phase_fetch)
            inst_mem_addr <= pc_next;
         if (accept) begin
            inst       <= inst_mem_rdata;
            curr_pc_fd <= inst_mem_addr;
            next_pc_fd <= inst_mem_addr + XLEN'(4);
         end
      end
   end
endmodule
